// File: rtl/cpu_hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - forward-select encodings driven onto the EX operand muxes
//   - RV32 opcode constants used by the ID-stage operand-use decode
//   - shadow-stage record types for EX and for the MEM/WB write-back info
package cpu_hazard_pkg;

    localparam int RA_W = 5;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;

    typedef struct packed {
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic            reg_write;
        logic            mem_read;
    } ex_stage_t;

    typedef struct packed {
        logic [RA_W-1:0] rd;
        logic            reg_write;
    } wr_stage_t;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Pure combinational operand-forwarding comparator.
// Ports:
//   ex_rs1, ex_rs2       source registers of the instruction in EX
//   mem_rd/mem_reg_write destination info of the instruction in MEM
//   wb_rd/wb_reg_write   destination info of the instruction in WB
//   forward_a/forward_b  EX operand selects (FWD_REG / FWD_WB / FWD_MEM)
module hazard_fwd_unit
    import cpu_hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_reg_write,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b
);

    // The younger producer (MEM) wins; x0 is hard-wired and never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] m_rd,
        input logic                  m_we,
        input logic [REG_ADDR_W-1:0] w_rd,
        input logic                  w_we
    );
        if (m_we && (m_rd != '0) && (m_rd == rs))
            return FWD_MEM;
        else if (w_we && (w_rd != '0) && (w_rd == rs))
            return FWD_WB;
        else
            return FWD_REG;
    endfunction

    always_comb begin
        forward_a = fwd_sel(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
        forward_b = fwd_sel(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage RISC-V pipeline.
// Keeps a shadow copy of EX/MEM/WB destination info and derives operand
// forwarding, a 1-cycle load-use stall and the redirect flushes.
// Ports:
//   clk, rst (sync, active high), enable (pipeline advance)
//   id_instr, id_reg_write, id_mem_read  ID-stage instruction and controls
//   mem_redirect                        branch taken / jump resolved in MEM
//   forward_a, forward_b                EX operand mux selects
//   stall, bubble_id_ex                 load-use hold / ID_EX bubble
//   flush_if_id, flush_id_ex, flush_ex_mem  redirect squash
//   stall_cnt, flush_cnt                perf counters
// Optional: define HAZARD_PERF_CNT_EN to build the saturating stall/redirect
// counters; without it both counter outputs are tied to 0.
module pipeline_hazard_ctrl
    import cpu_hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [31:0]      id_instr,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             mem_redirect,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic             stall,
    output logic             bubble_id_ex,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ex_stage_t ex_q, id_d;
    wr_stage_t mem_q, wb_q, mem_d;
    logic [6:0] id_op;
    logic       rs1_used, rs2_used, load_use;

    // funct fields and the upper immediate bits play no part in hazard detection
    logic unused_id_bits;
    assign unused_id_bits = ^{id_instr[31:25], id_instr[14:12]};

    assign id_op = id_instr[6:0];

    always_comb begin
        rs1_used = !((id_op == OP_LUI) || (id_op == OP_AUIPC) || (id_op == OP_JAL));
        rs2_used = (id_op == OP_RTYPE) || (id_op == OP_STORE) || (id_op == OP_BRANCH);

        id_d           = '0;
        id_d.rs1       = id_instr[19:15];
        id_d.rs2       = id_instr[24:20];
        id_d.rd        = id_instr[11:7];
        id_d.reg_write = id_reg_write;
        id_d.mem_read  = id_mem_read;

        mem_d           = '0;
        mem_d.rd        = ex_q.rd;
        mem_d.reg_write = ex_q.reg_write;

        load_use = ex_q.mem_read && (ex_q.rd != '0) &&
                   ((rs1_used && (ex_q.rd == id_d.rs1)) ||
                    (rs2_used && (ex_q.rd == id_d.rs2)));
    end

    // The bubble clears EX.mem_read, so a load-use stall never repeats.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (enable) begin
            if (load_use || mem_redirect) ex_q <= '0;
            else                          ex_q <= id_d;
            if (mem_redirect) mem_q <= '0;
            else              mem_q <= mem_d;
            wb_q <= mem_q;
        end
    end

    // A redirect squashes the stalled instruction anyway, so it wins.
    assign stall        = enable && load_use && !mem_redirect;
    assign bubble_id_ex = stall;
    assign flush_if_id  = enable && mem_redirect;
    assign flush_id_ex  = enable && mem_redirect;
    assign flush_ex_mem = enable && mem_redirect;

    hazard_fwd_unit #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd (
        .ex_rs1        (ex_q.rs1),
        .ex_rs2        (ex_q.rs2),
        .mem_rd        (mem_q.rd),
        .mem_reg_write (mem_q.reg_write),
        .wb_rd         (wb_q.rd),
        .wb_reg_write  (wb_q.reg_write),
        .forward_a     (forward_a),
        .forward_b     (forward_b)
    );

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (enable && mem_redirect && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Each step drives the ID-stage
// inputs for one cycle and, when checked, queues the expected output vector
// {forward_a, forward_b, stall, bubble, flush_if_id, flush_id_ex, flush_ex_mem}
// which is popped and compared at the following negedge. Counter outputs are
// compared against a running model (0 when HAZARD_PERF_CNT_EN is undefined).
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst, enable, id_reg_write, id_mem_read, mem_redirect;
    logic [31:0] id_instr;
    logic [1:0]  forward_a, forward_b;
    logic        stall, bubble_id_ex, flush_if_id, flush_id_ex, flush_ex_mem;
    logic [31:0] stall_cnt, flush_cnt;

    typedef struct {
        string      tag;
        logic [8:0] val;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned m_stall = 0;
    int unsigned m_flush = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .id_instr     (id_instr),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .mem_redirect (mem_redirect),
        .forward_a    (forward_a),
        .forward_b    (forward_b),
        .stall        (stall),
        .bubble_id_ex (bubble_id_ex),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .flush_ex_mem (flush_ex_mem),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rty(input logic [6:0] f7, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [2:0] f3);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] ld(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b011, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1);
        return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
    endfunction

    task automatic step(input string tag, input logic [31:0] instr, input logic rw,
                        input logic mr, input logic redir, input logic en,
                        input logic chk, input logic [8:0] expv);
        exp_t       e;
        logic [8:0] obs;
        id_instr     = instr;
        id_reg_write = rw;
        id_mem_read  = mr;
        mem_redirect = redir;
        enable       = en;
        if (chk) sb.push_back('{tag, expv});
        @(negedge clk);
        if (chk) begin
            e   = sb.pop_front();
            obs = {forward_a, forward_b, stall, bubble_id_ex,
                   flush_if_id, flush_id_ex, flush_ex_mem};
            n_tests++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.val);
            end
            n_tests++;
            assert (stall_cnt === 32'(m_stall)) else begin
                n_fail++;
                $error("FAIL %s_stall_cnt observed=%0d expected=%0d", e.tag, stall_cnt, m_stall);
            end
            n_tests++;
            assert (flush_cnt === 32'(m_flush)) else begin
                n_fail++;
                $error("FAIL %s_flush_cnt observed=%0d expected=%0d", e.tag, flush_cnt, m_flush);
            end
        end
        @(posedge clk);
        if (rst) begin
            m_stall = 0;
            m_flush = 0;
        end else if (en) begin
`ifdef HAZARD_PERF_CNT_EN
            if (chk && expv[4]) m_stall++;
            if (redir)          m_flush++;
`endif
        end
        #1;
    endtask

    initial begin
        rst = 1'b1;
        step("rst0", NOP, 1, 0, 0, 1, 0, '0);
        step("rst1", NOP, 1, 0, 0, 1, 0, '0);
        rst = 1'b0;
        step("reset_state", NOP, 1, 0, 0, 1, 1, 9'b00_00_00_000);

        // EX->EX: add x5,x1,x2 ; sub x6,x5,x3
        step("idle",       rty(7'h00, 5, 1, 2, 3'b000), 1, 0, 0, 1, 1, 9'b00_00_00_000);
        step("add_in_ex",  rty(7'h20, 6, 5, 3, 3'b000), 1, 0, 0, 1, 1, 9'b00_00_00_000);
        step("ex_ex_fwd",  NOP,                          1, 0, 0, 1, 1, 9'b10_00_00_000);
        // add x5 ; nop ; or x7,x4,x5
        step("c1_a",       rty(7'h00, 5, 1, 2, 3'b000), 1, 0, 0, 1, 1, 9'b00_00_00_000);
        step("c1_b",       NOP,                          1, 0, 0, 1, 1, 9'b00_00_00_000);
        step("c1_c",       rty(7'h00, 7, 4, 5, 3'b110), 1, 0, 0, 1, 1, 9'b00_00_00_000);
        // or in EX sees x5 in WB; next two adds set up the priority case
        step("wb_fwd_b",   rty(7'h00, 5, 1, 2, 3'b000), 1, 0, 0, 1, 1, 9'b00_01_00_000);
        step("c2_a",       rty(7'h00, 5, 3, 4, 3'b000), 1, 0, 0, 1, 1, 9'b00_00_00_000);
        step("c2_b",       rty(7'h00, 7, 5, 0, 3'b110), 1, 0, 0, 1, 1, 9'b00_00_00_000);
        step("mem_prio",   NOP,                          1, 0, 0, 1, 1, 9'b10_00_00_000);

        // Load-use: ld x8,0(x1) ; add x9,x8,x2
        step("lu_a",       ld(8, 1),                     1, 1, 0, 1, 1, 9'b00_00_00_000);
        step("lu_stall",   rty(7'h00, 9, 8, 2, 3'b000), 1, 0, 0, 1, 1, 9'b00_00_11_000);
        step("lu_1cycle",  rty(7'h00, 9, 8, 2, 3'b000), 1, 0, 0, 1, 1, 9'b00_00_00_000);
        step("lu_wb_fwd",  NOP,                          1, 0, 0, 1, 1, 9'b01_00_00_000);
        // ld x0 followed by a reader of x0: no stall, no forward of x0
        step("ldx0_a",     ld(0, 1),                     1, 1, 0, 1, 1, 9'b00_00_00_000);
        step("ldx0_nostl", rty(7'h00, 11, 0, 2, 3'b000),1, 0, 0, 1, 1, 9'b00_00_00_000);

        // Redirect squashes add x11 in EX; its reader must see no forward
        step("redir",      rty(7'h00, 12, 11, 11, 3'b000), 1, 0, 1, 1, 1, 9'b00_00_00_111);
        step("post_redir", rty(7'h00, 12, 11, 11, 3'b000), 1, 0, 0, 1, 1, 9'b00_00_00_000);
        step("no_sq_fwd",  NOP,                          1, 0, 0, 1, 1, 9'b00_00_00_000);
        // Back-to-back redirects
        step("b2b_1",      NOP,                          1, 0, 1, 1, 1, 9'b00_00_00_111);
        step("b2b_2",      NOP,                          1, 0, 1, 1, 1, 9'b00_00_00_111);
        step("b2b_done",   NOP,                          1, 0, 0, 1, 1, 9'b00_00_00_000);

        // Redirect in the same cycle as a load-use match
        step("rlu_a",      ld(8, 1),                     1, 1, 0, 1, 1, 9'b00_00_00_000);
        step("rlu_redir",  rty(7'h00, 9, 8, 2, 3'b000), 1, 0, 1, 1, 1, 9'b00_00_00_111);
        step("rlu_nostl",  rty(7'h00, 9, 8, 2, 3'b000), 1, 0, 0, 1, 1, 9'b00_00_00_000);

        // Load-use through rs2 of a store
        step("st_a",       ld(13, 2),                    1, 1, 0, 1, 1, 9'b00_00_00_000);
        step("st_stall",   sw(13, 1),                    0, 0, 0, 1, 1, 9'b00_00_11_000);
        step("st_1cycle",  sw(13, 1),                    0, 0, 0, 1, 1, 9'b00_00_00_000);

        // enable=0: state holds (sw in EX, ld x13 in WB), redirect gives no flush
        step("en0_1",      NOP,                          1, 0, 1, 0, 1, 9'b00_01_00_000);
        step("en0_2",      NOP,                          1, 0, 1, 0, 1, 9'b00_01_00_000);
        step("en0_3",      NOP,                          1, 0, 1, 0, 1, 9'b00_01_00_000);
        step("en1_held",   NOP,                          1, 0, 0, 1, 1, 9'b00_01_00_000);

        // Reset mid-sequence with a pending load-use, and with enable low
        step("pre_rst",    ld(8, 1),                     1, 1, 0, 1, 0, '0);
        rst = 1'b1;
        step("in_rst",     rty(7'h00, 9, 8, 2, 3'b000), 1, 0, 0, 0, 0, '0);
        rst = 1'b0;
        step("rst_clears", rty(7'h00, 9, 8, 2, 3'b000), 1, 0, 0, 1, 1, 9'b00_00_00_000);

        n_tests++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
